shared_buffer_read_scheduler: RTL and testbench
===============================================

Name: shared_buffer_read_scheduler

Overview:
- Read-side controller for the shared linked-list packet buffer.
- Tracks the lengths of committed packets for each output port and picks a non-empty port round-robin.
- Issues one buffer rd_req/op pulse per word for the whole packet, with no interleaving between ports.
- Produces framing signals (valid, port, sop, eop) aligned with the buffer's odata, which has 1-cycle read latency, for the downstream egress stage.

Parameters:
- NUM_PORTS, 8, number of output ports (queues) in the shared buffer.
- PORT_W, 3, port index width, equal to ceil(log2(NUM_PORTS)).
- LEN_W, 8, packet length width in words (matches the buffer's packet_len).
- LQ_DEPTH, 4, per-port length-queue depth; must be a power of 2.
- N, 13, buffer port-address width driven on op.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
- pkt_enq  in  1  1-cycle pulse: a complete packet has been committed to the buffer.
- pkt_enq_port  in  PORT_W  destination port of the committed packet.
- pkt_enq_len  in  LEN_W  length of the committed packet in words.
- pkt_enq_full  out  NUM_PORTS  per-port flag: that port's length queue is full.
- enq_err  out  1  1-cycle pulse: an enqueue was dropped because the queue was full or the length was 0.
- buf_empty  in  1  shared_buffer_empty from the buffer.
- rd_req  out  1  read strobe to the buffer.
- op  out  N  port select to the buffer; zero-extended from PORT_W.
- out_ready  in  1  downstream will accept the word returned in the next cycle.
- out_valid  out  1  the buffer's odata is valid this cycle.
- out_port  out  PORT_W  port of the current word.
- out_sop  out  1  current word is the first word of its packet.
- out_eop  out  1  current word is the last word of its packet.
- busy  out  1  a packet read is in progress.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - All length queues are emptied.
  - FSM goes to IDLE and last_grant is set to NUM_PORTS-1.
  - rd_req, op, out_valid, out_sop, out_eop, out_port, busy, enq_err and pkt_enq_full all read 0 from the next cycle.
  - Reset in the middle of a packet abandons it; the buffer is reset by the same rst.
- Length queues (one circular FIFO per port, LQ_DEPTH entries of LEN_W):
  - A pkt_enq with len > 0 and the target queue not full pushes len.
  - Otherwise the packet is dropped and enq_err pulses in the next cycle.
  - pkt_enq_full[p] is registered and reflects the queue count after the current cycle's push/pop.
  - A push and a pop on the same port in the same cycle are both applied, so the count is unchanged.
  - A push to a full queue that coincides with a pop on that queue is accepted.
- FSM states are IDLE and READ.
- IDLE:
  - If buf_empty = 0 and any queue is non-empty, grant the first non-empty port searching from last_grant+1 upward, wrapping modulo NUM_PORTS.
  - Latch that port and the length at the head of its queue, set wcnt = 0, and go to READ.
  - No rd_req is issued in IDLE, so there is a minimum 1 idle cycle between packets.
- READ:
  - Each cycle with out_ready = 1: rd_req = 1, op = granted port, wcnt++.
  - With out_ready = 0: rd_req = 0 and the state is held.
  - On the cycle issuing word wcnt = len-1: pop the head of the queue, set last_grant = granted port, and go to IDLE.
  - busy = 1 throughout READ.
- Output alignment:
  - out_valid, out_port, out_sop and out_eop are registered copies of (rd_req, op, wcnt == 0, wcnt == len-1).
  - They therefore appear 1 cycle after rd_req, aligned with odata.
  - For a len = 1 packet, sop and eop are both asserted on the same word.
- buf_empty asserting during READ is not a stop condition: the queue accounting is authoritative.
- Arithmetic:
  - wcnt is LEN_W bits wide and compared against the latched len; it cannot overflow because len ≤ 2^LEN_W-1.
  - The circular-FIFO pointers are log2(LQ_DEPTH) bits, plus one extra bit for full/empty detection.

Test Plan:
- Single packet: after reset, pkt_enq port 3 len 3, out_ready = 1.
  - Required: rd_req high for 3 consecutive cycles starting 2 cycles after the enq, with op = 3.
  - out_valid follows 1 cycle later, with sop on word 0 and eop on word 2; busy then falls.
- Round-robin: enqueue len-2 packets on ports 0, 5, 3, then a second packet on port 0.
  - Required grant order: 0, 3, 5, 0.
  - Each packet is exactly 2 contiguous rd_req pulses, with 1 idle cycle between packets.
- Backpressure: port 1 len 4, out_ready toggling 1, 0, 0, 1, 1, 1.
  - Required: rd_req exactly where out_ready = 1, 4 pulses in total.
  - sop on the first valid word, eop on the fourth; no words are lost or duplicated.
- Queue full:
  - 4 enqueues to port 2 set pkt_enq_full[2] = 1; a 5th enqueue gives an enq_err pulse and no extra packet read.
  - Enqueuing len 0 gives enq_err.
  - An enqueue that coincides with the final pop of a full queue is accepted, and the count stays at 4.
- Reset mid-packet: port 6 len 5, assert rst = 0 after 2 rd_req pulses.
  - Required: from the next cycle rd_req and out_valid are 0, all queues are empty, and last_grant = NUM_PORTS-1.
  - A subsequent enqueue on port 0 is served first.

Source files
------------

// File: rtl/shared_buffer_read_scheduler.sv
// Read-side scheduler for the shared packet buffer. It keeps a queue of packet lengths
// per port, grants a port round-robin, reads the whole packet, and emits framing aligned with odata.
module shared_buffer_read_scheduler #(
    parameter int NUM_PORTS = 8,
    parameter int PORT_W    = 3,
    parameter int LEN_W     = 8,
    parameter int LQ_DEPTH  = 4,
    parameter int N         = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_enq,
    input  logic [PORT_W-1:0]    pkt_enq_port,
    input  logic [LEN_W-1:0]     pkt_enq_len,
    output logic [NUM_PORTS-1:0] pkt_enq_full,
    output logic                 enq_err,
    input  logic                 buf_empty,
    output logic                 rd_req,
    output logic [N-1:0]         op,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [PORT_W-1:0]    out_port,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 busy
);
    localparam int PTR_W = $clog2(LQ_DEPTH);

    typedef enum logic {IDLE, READ} state_t;

    state_t            state_q, state_d;
    logic [PORT_W-1:0] grant_q, grant_d, last_grant_q, last_grant_d;
    logic [LEN_W-1:0]  len_q, len_d, wcnt_q, wcnt_d;

    logic [LEN_W-1:0]  lq_mem_q [NUM_PORTS][LQ_DEPTH];
    logic [LEN_W-1:0]  lq_mem_d [NUM_PORTS][LQ_DEPTH];
    logic [PTR_W:0]    wr_ptr_q [NUM_PORTS];
    logic [PTR_W:0]    wr_ptr_d [NUM_PORTS];
    logic [PTR_W:0]    rd_ptr_q [NUM_PORTS];
    logic [PTR_W:0]    rd_ptr_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] lq_empty, lq_full, full_q, full_d;

    logic              out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic [PORT_W-1:0] out_port_q, out_port_d;
    logic              enq_err_q, enq_err_d;

    logic [PORT_W-1:0] pick, cand;
    logic              found, last_word, enq_ok;

    // The extra pointer bit separates the full case from the empty case when the index bits match.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            lq_empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
            lq_full[p]  = ((wr_ptr_q[p] ^ rd_ptr_q[p]) == {1'b1, {PTR_W{1'b0}}});
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PORT_W'((int'(last_grant_q) + i) % NUM_PORTS);
            if (!found && !lq_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        len_d        = len_q;
        wcnt_d       = wcnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: if (!buf_empty && found) begin
                state_d = READ;
                grant_d = pick;
                len_d   = lq_mem_q[pick][rd_ptr_q[pick][PTR_W-1:0]];
                wcnt_d  = '0;
            end
            READ: if (out_ready) begin
                wcnt_d = wcnt_q + 1'b1;
                if (wcnt_q == len_q - 1'b1) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == READ);
        rd_req    = busy && out_ready;
        op        = rd_req ? N'(grant_q) : '0;
        last_word = rd_req && (wcnt_q == len_q - 1'b1);
    end

    // A push to a full queue is accepted only when the final word of that queue's head packet is read in the same cycle.
    always_comb begin
        lq_mem_d = lq_mem_q;
        enq_ok   = pkt_enq && (pkt_enq_len != '0) &&
                   (!lq_full[pkt_enq_port] || (last_word && grant_q == pkt_enq_port));
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p];
            rd_ptr_d[p] = rd_ptr_q[p];
            if (last_word && grant_q == PORT_W'(p))
                rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
            if (enq_ok && pkt_enq_port == PORT_W'(p)) begin
                lq_mem_d[p][wr_ptr_q[p][PTR_W-1:0]] = pkt_enq_len;
                wr_ptr_d[p] = wr_ptr_q[p] + 1'b1;
            end
            full_d[p] = ((wr_ptr_d[p] ^ rd_ptr_d[p]) == {1'b1, {PTR_W{1'b0}}});
        end
        enq_err_d = pkt_enq && !enq_ok;
    end

    always_comb begin
        out_valid_d = rd_req;
        out_port_d  = rd_req ? grant_q : '0;
        out_sop_d   = rd_req && (wcnt_q == '0);
        out_eop_d   = last_word;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            len_q        <= '0;
            wcnt_q       <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
            end
            full_q       <= '0;
            enq_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_port_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            full_q       <= full_d;
            enq_err_q    <= enq_err_d;
            out_valid_q  <= out_valid_d;
            out_port_q   <= out_port_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
        end
    end

    // Storage needs no reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        lq_mem_q <= lq_mem_d;
    end

    assign pkt_enq_full = full_q;
    assign enq_err      = enq_err_q;
    assign out_valid    = out_valid_q;
    assign out_port     = out_port_q;
    assign out_sop      = out_sop_q;
    assign out_eop      = out_eop_q;
endmodule

// File: tb/tb_shared_buffer_read_scheduler.sv
// Bench for shared_buffer_read_scheduler: a queue-based packet model is checked every cycle,
// directed scenarios are followed by a randomized soak.
module tb_shared_buffer_read_scheduler;
    localparam int NP = 8, PW = 3, LW = 8, D = 4, NW = 13;

    logic          clk = 1'b0, rst = 1'b0;
    logic          pkt_enq = 1'b0, buf_empty = 1'b0, out_ready = 1'b0;
    logic [PW-1:0] pkt_enq_port = '0;
    logic [LW-1:0] pkt_enq_len = '0;
    logic [NP-1:0] pkt_enq_full;
    logic          enq_err, rd_req, out_valid, out_sop, out_eop, busy;
    logic [NW-1:0] op;
    logic [PW-1:0] out_port;

    shared_buffer_read_scheduler #(.NUM_PORTS(NP), .PORT_W(PW), .LEN_W(LW), .LQ_DEPTH(D), .N(NW)) dut (
        .clk(clk), .rst(rst), .pkt_enq(pkt_enq), .pkt_enq_port(pkt_enq_port),
        .pkt_enq_len(pkt_enq_len), .pkt_enq_full(pkt_enq_full), .enq_err(enq_err),
        .buf_empty(buf_empty), .rd_req(rd_req), .op(op), .out_ready(out_ready),
        .out_valid(out_valid), .out_port(out_port), .out_sop(out_sop), .out_eop(out_eop),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    bit chk_en = 1'b0;

    // Model: pending packet lengths per port plus the packet currently being read.
    int mq [NP][$];
    bit m_rd = 1'b0;
    int m_port = 0, m_len = 0, m_w = 0, m_last = NP - 1;
    logic          e_valid = 1'b0, e_sop = 1'b0, e_eop = 1'b0, e_err = 1'b0;
    logic [PW-1:0] e_port = '0;
    logic [NP-1:0] e_full = '0;
    int sop_log[$];
    int word_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit enq, input int port, input int len, input bit rdy,
                         input bit bemp, input bit r);
        bit exp_rd, pop, ok;
        pkt_enq      = enq;
        pkt_enq_port = PW'(port);
        pkt_enq_len  = LW'(len);
        out_ready    = rdy;
        buf_empty    = bemp;
        rst          = r;
        #1;
        exp_rd = m_rd && rdy;
        if (chk_en) begin
            chk("rd_req", 32'(rd_req), 32'(exp_rd));
            chk("op", 32'(op), exp_rd ? 32'(m_port) : 32'd0);
            chk("busy", 32'(busy), 32'(m_rd));
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("out_port", 32'(out_port), 32'(e_port));
            chk("out_sop", 32'(out_sop), 32'(e_sop));
            chk("out_eop", 32'(out_eop), 32'(e_eop));
            chk("enq_err", 32'(enq_err), 32'(e_err));
            chk("pkt_enq_full", 32'(pkt_enq_full), 32'(e_full));
        end
        if (out_valid === 1'b1) begin
            word_cnt++;
            if (out_sop === 1'b1) sop_log.push_back(int'(out_port));
        end
        if (!r) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            m_rd = 0; m_w = 0; m_last = NP - 1;
            e_valid = 0; e_port = '0; e_sop = 0; e_eop = 0; e_err = 0; e_full = '0;
        end else begin
            pop     = exp_rd && (m_w == m_len - 1);
            e_valid = exp_rd;
            e_port  = exp_rd ? PW'(m_port) : '0;
            e_sop   = exp_rd && (m_w == 0);
            e_eop   = pop;
            ok      = enq && (len != 0) && (mq[port].size() < D || (pop && m_port == port));
            e_err   = enq && !ok;
            if (m_rd) begin
                if (exp_rd) m_w++;
                if (pop) begin
                    void'(mq[m_port].pop_front());
                    m_last = m_port;
                    m_rd   = 0;
                end
            end else if (!bemp) begin
                for (int i = 1; i <= NP; i++) begin
                    int c = (m_last + i) % NP;
                    if (mq[c].size() > 0) begin
                        m_rd = 1; m_port = c; m_len = mq[c][0]; m_w = 0;
                        break;
                    end
                end
            end
            if (ok) mq[port].push_back(len);
            for (int p = 0; p < NP; p++) e_full[p] = (mq[p].size() == D);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy, input bit bemp);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, rdy, bemp, 1);
    endtask

    initial begin
        int exp_rr[4];
        bit bp[6];
        int k;
        exp_rr = '{0, 3, 5, 0};
        bp     = '{1, 0, 0, 1, 1, 1};
        @(negedge clk);
        cycle(0, 0, 0, 1, 0, 0);
        chk_en = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_full", 32'(pkt_enq_full), 32'd0);

        // Single packet
        sop_log.delete(); word_cnt = 0;
        cycle(1, 3, 3, 1, 0, 1);
        idle(8, 1, 0);
        chk("single_npkt", sop_log.size(), 1);
        chk("single_port", sop_log[0], 3);
        chk("single_words", word_cnt, 3);

        // Round-robin order
        sop_log.delete(); word_cnt = 0;
        cycle(1, 0, 2, 1, 0, 1);
        cycle(1, 5, 2, 1, 0, 1);
        cycle(1, 3, 2, 1, 0, 1);
        cycle(1, 0, 2, 1, 0, 1);
        idle(16, 1, 0);
        chk("rr_npkt", sop_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", sop_log[i], exp_rr[i]);
        chk("rr_words", word_cnt, 8);

        // Backpressure
        sop_log.delete(); word_cnt = 0;
        cycle(1, 1, 4, 1, 0, 1);
        idle(1, 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, bp[i], 0, 1);
        idle(4, 1, 0);
        chk("bp_words", word_cnt, 4);
        chk("bp_port", sop_log[0], 1);

        // Queue full, len 0, push coinciding with the final pop
        sop_log.delete(); word_cnt = 0;
        for (int i = 0; i < 4; i++) cycle(1, 2, 2, 1, 1, 1);
        chk("full2_set", 32'(pkt_enq_full[2]), 32'd1);
        cycle(1, 2, 2, 1, 1, 1);
        chk("err_full", 32'(enq_err), 32'd1);
        cycle(1, 2, 0, 1, 1, 1);
        chk("err_len0", 32'(enq_err), 32'd1);
        k = 0;
        while (k < 20 && !(m_rd && m_w == m_len - 1)) begin
            idle(1, 1, 0);
            k++;
        end
        chk("coincide_reached", 32'(k < 20), 32'd1);
        cycle(1, 2, 3, 1, 0, 1);
        chk("coincide_err", 32'(enq_err), 32'd0);
        chk("coincide_full", 32'(pkt_enq_full[2]), 32'd1);
        idle(30, 1, 0);
        chk("full_npkt", sop_log.size(), 5);
        chk("full_words", word_cnt, 11);

        // Reset in the middle of a packet
        cycle(1, 6, 5, 1, 0, 1);
        idle(3, 1, 0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(pkt_enq_full), 32'd0);
        sop_log.delete(); word_cnt = 0;
        cycle(1, 7, 1, 1, 1, 1);
        cycle(1, 0, 1, 1, 1, 1);
        idle(8, 1, 0);
        chk("rst_npkt", sop_log.size(), 2);
        chk("rst_first", sop_log[0], 0);
        chk("rst_second", sop_log[1], 7);

        // Randomized soak
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, NP - 1), $urandom_range(0, 6),
                  $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 199) != 0);
        idle(120, 1, 0);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
